// File: rtl/core_multicycle.sv
// Multi-cycle RV32I core (LUI/AUIPC/JAL/JALR/branches/LW/SW/OP-IMM/OP) on one shared memory port.
// Ports: clk, reset (sync, active-high); mem_req/we/addr/wdata out, mem_rdata/ack in; leds, trap, instret out.
module core_multicycle #(
   parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
   parameter int          NUM_LEDS     = 8,
   parameter int          LED_REG      = 1
) (
   input  logic                clk,
   input  logic                reset,
   output logic                mem_req,
   output logic                mem_we,
   output logic [31:0]         mem_addr,
   output logic [31:0]         mem_wdata,
   input  logic [31:0]         mem_rdata,
   input  logic                mem_ack,
   output logic [NUM_LEDS-1:0] leds,
   output logic                trap,
   output logic [31:0]         instret
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_OP     = 7'h33;

   state_t      state;
   logic [31:0] pc, ir;
   logic [31:0] rs1_q, rs2_q, imm_q;
   logic [31:0] wb_q, next_pc_q;
   logic [31:0] regs [32];

   logic [6:0] opcode, f7;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] f3;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign f3     = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign f7     = ir[31:25];

   assign leds = regs[LED_REG][NUM_LEDS-1:0];

   logic [31:0] rf_rs1, rf_rs2;
   assign rf_rs1 = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
   assign rf_rs2 = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

   logic [31:0] imm_dec;
   logic        illegal;
   always_comb begin
      imm_dec = {{20{ir[31]}}, ir[31:20]};
      illegal = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC: imm_dec = {ir[31:12], 12'h000};
         OP_JAL: imm_dec = {{11{ir[31]}}, ir[31], ir[19:12],
                            ir[20], ir[30:21], 1'b0};
         OP_JALR: illegal = (f3 != 3'b000);
         OP_BRANCH: begin
            imm_dec = {{19{ir[31]}}, ir[31], ir[7],
                       ir[30:25], ir[11:8], 1'b0};
            illegal = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OP_LOAD: illegal = (f3 != 3'b010);
         OP_STORE: begin
            imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            illegal = (f3 != 3'b010);
         end
         OP_IMM: begin
            if (f3 == 3'b001)
               illegal = (f7 != 7'h00);
            else if (f3 == 3'b101)
               illegal = (f7 != 7'h00) && (f7 != 7'h20);
         end
         OP_OP: illegal = !((f7 == 7'h00) ||
                            ((f7 == 7'h20) &&
                             ((f3 == 3'b000) || (f3 == 3'b101))));
         default: illegal = 1'b1;
      endcase
   end

   // alt selects SUB/SRA; for OP-IMM only SRAI carries it (ADDI imm bit 10 must not)
   logic [31:0] op_b, alu_res;
   logic        alt;
   assign op_b = (opcode == OP_OP) ? rs2_q : imm_q;
   assign alt  = f7[5] && ((opcode == OP_OP) || (f3 == 3'b101));

   always_comb begin
      alu_res = 32'h0;
      case (f3)
         3'b000: alu_res = alt ? rs1_q - op_b : rs1_q + op_b;
         3'b001: alu_res = rs1_q << op_b[4:0];
         3'b010: alu_res = {31'h0, $signed(rs1_q) < $signed(op_b)};
         3'b011: alu_res = {31'h0, rs1_q < op_b};
         3'b100: alu_res = rs1_q ^ op_b;
         3'b101: alu_res = alt ? 32'($signed(rs1_q) >>> op_b[4:0])
                               : rs1_q >> op_b[4:0];
         3'b110: alu_res = rs1_q | op_b;
         default: alu_res = rs1_q & op_b;
      endcase
   end

   logic taken;
   always_comb begin
      case (f3)
         3'b000: taken = (rs1_q == rs2_q);
         3'b001: taken = (rs1_q != rs2_q);
         3'b100: taken = $signed(rs1_q) < $signed(rs2_q);
         3'b101: taken = $signed(rs1_q) >= $signed(rs2_q);
         3'b110: taken = rs1_q < rs2_q;
         3'b111: taken = rs1_q >= rs2_q;
         default: taken = 1'b0;
      endcase
   end

   logic [31:0] pc_plus4, next_pc, wb_val, eff_addr;
   logic        is_mem, writes_rd;
   assign pc_plus4  = pc + 32'd4;
   assign eff_addr  = rs1_q + imm_q;
   assign is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
   assign writes_rd = (opcode != OP_BRANCH) && (opcode != OP_STORE);

   always_comb begin
      next_pc = pc_plus4;
      wb_val  = alu_res;
      case (opcode)
         OP_LUI:   wb_val = imm_q;
         OP_AUIPC: wb_val = pc + imm_q;
         OP_JAL: begin
            wb_val  = pc_plus4;
            next_pc = pc + imm_q;
         end
         OP_JALR: begin
            wb_val  = pc_plus4;
            next_pc = eff_addr & ~32'h1;
         end
         OP_BRANCH: if (taken) next_pc = pc + imm_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         pc        <= BOOT_ADDRESS;
         ir        <= 32'h0;
         rs1_q     <= 32'h0;
         rs2_q     <= 32'h0;
         imm_q     <= 32'h0;
         wb_q      <= 32'h0;
         next_pc_q <= 32'h0;
         instret   <= 32'h0;
         trap      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      end else begin
         unique case (state)
            S_FETCH: begin
               // first cycle after reset issues the request; later
               // fetches are issued straight from WRITEBACK
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end else if (mem_ack) begin
                  ir      <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               rs1_q <= rf_rs1;
               rs2_q <= rf_rs2;
               imm_q <= imm_dec;
               if (illegal) begin
                  trap  <= 1'b1;
                  state <= S_TRAP;
               end else begin
                  state <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               next_pc_q <= next_pc;
               wb_q      <= wb_val;
               if ((next_pc[1:0] != 2'b00) ||
                   (is_mem && (eff_addr[1:0] != 2'b00))) begin
                  trap  <= 1'b1;
                  state <= S_TRAP;
               end else if (is_mem) begin
                  mem_req   <= 1'b1;
                  mem_we    <= (opcode == OP_STORE);
                  mem_addr  <= eff_addr;
                  mem_wdata <= rs2_q;
                  state     <= S_MEM;
               end else begin
                  state <= S_WRITEBACK;
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we) wb_q <= mem_rdata;
                  state <= S_WRITEBACK;
               end
            end
            S_WRITEBACK: begin
               if (writes_rd && (rd != 5'd0)) regs[rd] <= wb_q;
               pc       <= next_pc_q;
               instret  <= instret + 32'd1;
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= next_pc_q;
               state    <= S_FETCH;
            end
            S_TRAP: mem_req <= 1'b0;
            default: state <= S_TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_core_multicycle.sv
// Directed bench for core_multicycle with a wait-state memory model.
// Ports: drives clk/reset/mem_rdata/mem_ack, observes all outputs.
module tb_core_multicycle;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  leds;
   logic        trap;
   logic [31:0] instret;

   core_multicycle dut (
      .clk(clk), .reset(reset),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .leds(leds), .trap(trap), .instret(instret)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [256];
   logic [31:0] rd_log [64];
   logic [31:0] st_addr [8];
   logic [31:0] st_data [8];
   int rd_cnt, st_cnt, cyc, waits, wcnt;
   int checks = 0;
   int failures = 0;
   logic        busy;
   logic        h_we;
   logic [31:0] h_addr, h_wdata;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (reset) begin
         busy = 1'b0;
      end else if (mem_req) begin
         if (!busy) begin
            busy = 1'b1;
            wcnt = 0;
            h_we = mem_we;
            h_addr = mem_addr;
            h_wdata = mem_wdata;
            if (!mem_we && rd_cnt < 64) begin
               rd_log[rd_cnt] = mem_addr;
               rd_cnt++;
            end
         end else begin
            chk("hold_addr", 64'(mem_addr), 64'(h_addr));
            chk("hold_we_wdata", 64'({mem_we, mem_wdata}),
                64'({h_we, h_wdata}));
         end
         if (wcnt == waits) begin
            mem_ack = 1'b1;
            mem_rdata = mem[mem_addr[9:2]];
            if (mem_we) begin
               mem[mem_addr[9:2]] = mem_wdata;
               if (st_cnt < 8) begin
                  st_addr[st_cnt] = mem_addr;
                  st_data[st_cnt] = mem_wdata;
                  st_cnt++;
               end
            end
            busy = 1'b0;
         end else begin
            wcnt++;
         end
      end
   endtask

   task automatic go(input int n);
      while (cyc < n) tick();
   endtask

   task automatic run_until_trap(input int max);
      for (int i = 0; i < max && !trap; i++) tick();
      chk("trap_reached", 64'(trap), 64'd1);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0000_007F;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ack = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      busy = 1'b0;
      wcnt = 0;
      cyc = 0;
      rd_cnt = 0;
      st_cnt = 0;
   endtask

   initial begin
      reset = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      busy = 1'b0;

      // ADDI / SW / LW / ADD, zero-wait, cycle-exact
      clear_mem();
      mem[0] = 32'h05A0_0093;
      mem[1] = 32'h0410_2023;
      mem[2] = 32'h0400_2103;
      mem[3] = 32'h0021_00B3;
      waits = 0;
      do_reset();
      chk("rst_req", 64'(mem_req), 64'd0);
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_trap", 64'(trap), 64'd0);
      chk("rst_instret", 64'(instret), 64'd0);
      chk("rst_leds", 64'(leds), 64'd0);
      go(1);
      chk("c1_req", 64'(mem_req), 64'd1);
      chk("c1_addr", 64'(mem_addr), 64'd0);
      go(4);
      chk("c4_instret", 64'(instret), 64'd0);
      chk("c4_leds", 64'(leds), 64'd0);
      go(5);
      chk("c5_req", 64'(mem_req), 64'd1);
      chk("c5_addr", 64'(mem_addr), 64'h4);
      chk("c5_instret", 64'(instret), 64'd1);
      chk("c5_leds", 64'(leds), 64'h5A);
      go(8);
      chk("sw_req", 64'({mem_req, mem_we}), 64'b11);
      chk("sw_addr", 64'(mem_addr), 64'h40);
      chk("sw_wdata", 64'(mem_wdata), 64'h5A);
      go(10);
      chk("c10_addr", 64'(mem_addr), 64'h8);
      chk("c10_instret", 64'(instret), 64'd2);
      go(15);
      chk("c15_addr", 64'(mem_addr), 64'hC);
      go(19);
      chk("c19_addr", 64'(mem_addr), 64'h10);
      chk("c19_leds", 64'(leds), 64'hB4);
      go(21);
      chk("c21_trap", 64'(trap), 64'd1);
      chk("c21_req", 64'(mem_req), 64'd0);
      chk("c21_instret", 64'(instret), 64'd4);

      // SW/LW with three wait states per access
      clear_mem();
      mem[0] = 32'h05A0_0093;
      mem[1] = 32'h0010_2023;
      mem[2] = 32'h0000_2103;
      mem[3] = 32'h0021_00B3;
      waits = 3;
      do_reset();
      run_until_trap(400);
      chk("ws_instret", 64'(instret), 64'd4);
      chk("ws_leds", 64'(leds), 64'hB4);
      chk("ws_st_cnt", 64'(st_cnt), 64'd1);
      chk("ws_st_addr", 64'(st_addr[0]), 64'h0);
      chk("ws_st_data", 64'(st_data[0]), 64'h5A);
      chk("ws_rd_cnt", 64'(rd_cnt), 64'd6);
      chk("ws_lw_addr", 64'(rd_log[3]), 64'h0);

      // BEQ taken backwards
      clear_mem();
      mem[0] = 32'h0010_0093;
      mem[1] = 32'h0010_8093;
      mem[2] = 32'h0010_8093;
      mem[3] = 32'h0010_8093;
      mem[4] = 32'hFE00_0CE3;
      waits = 0;
      do_reset();
      go(21);
      chk("beq_addr", 64'(mem_addr), 64'h8);
      chk("beq_instret", 64'(instret), 64'd5);
      chk("beq_leds", 64'(leds), 64'h4);

      // BNE not taken, then illegal opcode at 0x14
      mem[4] = 32'hFE00_1CE3;
      do_reset();
      go(21);
      chk("bne_addr", 64'(mem_addr), 64'h14);
      go(22);
      chk("bne_c22_trap", 64'(trap), 64'd0);
      go(23);
      chk("bne_trap", 64'(trap), 64'd1);
      chk("bne_instret", 64'(instret), 64'd5);

      // JALR to 0x100, then JAL to misaligned 0x102
      clear_mem();
      mem[0]  = 32'h1010_01E7;
      mem[64] = 32'h0001_80B3;
      mem[65] = 32'hFFFF_F06F;
      do_reset();
      go(5);
      chk("jalr_addr", 64'(mem_addr), 64'h100);
      go(9);
      chk("jalr_link", 64'(leds), 64'h4);
      chk("jal_addr", 64'(mem_addr), 64'h104);
      go(12);
      chk("jal_trap", 64'(trap), 64'd1);
      go(22);
      chk("jal_req", 64'(mem_req), 64'd0);
      chk("jal_instret", 64'(instret), 64'd2);
      chk("jal_rd_cnt", 64'(rd_cnt), 64'd3);

      // illegal opcode, then a one-cycle reset
      clear_mem();
      do_reset();
      go(3);
      chk("ill_trap", 64'(trap), 64'd1);
      reset = 1'b1;
      tick();
      chk("rel_trap", 64'(trap), 64'd0);
      chk("rel_instret", 64'(instret), 64'd0);
      chk("rel_req", 64'(mem_req), 64'd0);
      reset = 1'b0;
      cyc = 0;
      tick();
      chk("rel_fetch", 64'({mem_req, mem_addr}), {31'h0, 1'b1, 32'h0});

      // reset while a fetch waits, with a same-cycle ack
      clear_mem();
      mem[0] = 32'h05A0_0093;
      waits = 3;
      do_reset();
      tick();
      tick();
      reset = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = 32'h0000_007F;
      tick();
      chk("rack_req", 64'(mem_req), 64'd0);
      chk("rack_instret", 64'(instret), 64'd0);
      reset = 1'b0;
      cyc = 0;
      rd_cnt = 0;
      waits = 0;
      tick();
      chk("rack_fetch", 64'({mem_req, mem_addr}), {31'h0, 1'b1, 32'h0});
      go(5);
      chk("rack_instret2", 64'(instret), 64'd1);
      chk("rack_leds", 64'(leds), 64'h5A);
      chk("rack_trap", 64'(trap), 64'd0);

      // ALU mix: SRAI, SLT, SLTU, SRL, XOR, ADD, AUIPC, illegal OP funct7
      clear_mem();
      mem[0]  = 32'hFF00_0113;
      mem[1]  = 32'h4021_5193;
      mem[2]  = 32'h0830_2023;
      mem[3]  = 32'h0001_2233;
      mem[4]  = 32'h0041_32B3;
      mem[5]  = 32'h0041_5333;
      mem[6]  = 32'h0043_43B3;
      mem[7]  = 32'h0053_83B3;
      mem[8]  = 32'h0870_2223;
      mem[9]  = 32'h0000_1097;
      mem[10] = 32'h4000_1033;
      do_reset();
      run_until_trap(200);
      chk("alu_st_cnt", 64'(st_cnt), 64'd2);
      chk("alu_srai", 64'({st_addr[0], st_data[0]}),
          {32'h80, 32'hFFFF_FFFC});
      chk("alu_mix", 64'({st_addr[1], st_data[1]}),
          {32'h84, 32'h7FFF_FFF9});
      chk("alu_auipc", 64'(leds), 64'h24);
      chk("alu_instret", 64'(instret), 64'd10);

      // misaligned LW traps without a data request
      clear_mem();
      mem[0] = 32'h0010_2083;
      do_reset();
      go(4);
      chk("mis_trap", 64'(trap), 64'd1);
      chk("mis_req", 64'(mem_req), 64'd0);
      go(8);
      chk("mis_rd_cnt", 64'(rd_cnt), 64'd1);
      chk("mis_instret", 64'(instret), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
